id_stage: RTL and testbench

- Decode stage of the RV32I 5-stage pipeline. Sits between the IF/ID register and the ID/EX register.
- Takes the fetched instruction and produces every input the ID/EX register consumes: EX/MEM/WB control, immediate, register indices, funct fields and operand values.
- Owns the 32x32 architectural register file (written from WB) and the load-use hazard unit that stalls fetch and inserts a bubble into ID/EX.

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/id_stage_reg_file.sv | 41 ++++
 rtl/id_stage.sv | 140 ++++++++++++++
 tb/tb_id_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op classes, mux selects and the
// bundle of control bits handed to the ID/EX register.
package rv32i_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_RTYPE = 2'b10;
  localparam logic [1:0] ULA_ITYPE = 2'b11;

  localparam logic MUX_B_REG  = 1'b0;
  localparam logic MUX_B_IMM  = 1'b1;
  localparam logic MUX_WB_ALU = 1'b0;
  localparam logic MUX_WB_MEM = 1'b1;

  typedef struct packed {
    logic [1:0] ula;
    logic       mux_ula;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       mux_reg_wr;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear, x0 hardwired to zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] rf [NREGS];

  assign rf[0] = '0;

  // Entry 0 has no storage, so writes addressed to x0 simply fall away.
  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          q_reg <= '0;
        else if (we && (waddr == AW'(gi)))
          q_reg <= wdata;
      end
      assign rf[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = rf[raddr_a];
  assign rdata_b = rf[raddr_b];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control/immediate decode, register file with WB
// write-through bypass, load-use hazard bubble and a sticky illegal flag.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   instr,
  input  logic              wb_reg_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        ula,
  output logic              mux_ula,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              reg_wr,
  output logic              mux_reg_wr,
  output logic [XLEN-1:0]   imm,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [6:0]        funct7,
  output logic [2:0]        funct3,
  output logic [XLEN-1:0]   val_A,
  output logic [XLEN-1:0]   val_B,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              illegal
);

  logic [6:0]      opcode;
  ctrl_t           dec_ctrl;
  ctrl_t           out_ctrl;
  logic            use_rs1;
  logic            use_rs2;
  logic            stall;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic            bypass_a;
  logic            bypass_b;
  logic            illegal_reg;
  logic            illegal_next;

  assign opcode = instr[6:0];
  assign rs1    = (opcode == OP_LUI) ? '0 : instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];

  always_comb begin
    dec_ctrl = '0;
    imm      = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl = '{ula: ULA_RTYPE, mux_ula: MUX_B_REG, mem_rd: 1'b0, mem_wr: 1'b0,
                     reg_wr: 1'b1, mux_reg_wr: MUX_WB_ALU};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl = '{ula: ULA_ITYPE, mux_ula: MUX_B_IMM, mem_rd: 1'b0, mem_wr: 1'b0,
                     reg_wr: 1'b1, mux_reg_wr: MUX_WB_ALU};
        imm      = {{20{instr[31]}}, instr[31:20]};
        use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl = '{ula: ULA_ADD, mux_ula: MUX_B_IMM, mem_rd: 1'b1, mem_wr: 1'b0,
                     reg_wr: 1'b1, mux_reg_wr: MUX_WB_MEM};
        imm      = {{20{instr[31]}}, instr[31:20]};
        use_rs1  = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl = '{ula: ULA_ADD, mux_ula: MUX_B_IMM, mem_rd: 1'b0, mem_wr: 1'b1,
                     reg_wr: 1'b0, mux_reg_wr: MUX_WB_ALU};
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl = '{ula: ULA_ADD, mux_ula: MUX_B_IMM, mem_rd: 1'b0, mem_wr: 1'b0,
                     reg_wr: 1'b1, mux_reg_wr: MUX_WB_ALU};
        imm      = {instr[31:12], 12'h000};
      end
      default: ;
    endcase
  end

  // The bubble clears ex_mem_rd at the next edge, so a stall never exceeds one cycle.
  assign stall = ex_mem_rd && (ex_rd != '0) &&
                 ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));

  assign out_ctrl     = (rst || stall) ? '0 : dec_ctrl;
  assign ula          = out_ctrl.ula;
  assign mux_ula      = out_ctrl.mux_ula;
  assign mem_rd       = out_ctrl.mem_rd;
  assign mem_wr       = out_ctrl.mem_wr;
  assign reg_wr       = out_ctrl.reg_wr;
  assign mux_reg_wr   = out_ctrl.mux_reg_wr;
  assign pc_enable    = rst || !stall;
  assign if_id_enable = rst || !stall;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(REG_AW)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_reg_wr),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  assign bypass_a = wb_reg_wr && (wb_rd != '0) && (wb_rd == rs1);
  assign bypass_b = wb_reg_wr && (wb_rd != '0) && (wb_rd == rs2);
  assign val_A    = rst ? '0 : (bypass_a ? wb_data : rf_a);
  assign val_B    = rst ? '0 : (bypass_b ? wb_data : rf_b);

  // A flushed IF/ID (instr == 0) must not flag, nor may an instruction being held by a stall.
  assign illegal_next = illegal_reg ||
                        ((instr != '0) && !is_supported(opcode) && !stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_reg <= 1'b0;
    else
      illegal_reg <= illegal_next;
  end

  assign illegal = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Randomized scoreboard bench for id_stage: the driver predicts each cycle's
// outputs from an ISA-level model; a negedge monitor pops and compares.
module tb_id_stage;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] va;
    logic [31:0] vb;
    logic [1:0]  en;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        wb_reg_wr = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_mem_rd = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ula;
  logic        mux_ula, mem_rd, mem_wr, reg_wr, mux_reg_wr;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] val_A, val_B;
  logic        pc_enable, if_id_enable, illegal;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  bit driver_done = 1'b0;

  logic [31:0] mregs [32];
  logic        mill;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .ula(ula),
    .mux_ula(mux_ula), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .mux_reg_wr(mux_reg_wr), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct7(funct7), .funct3(funct3), .val_A(val_A), .val_B(val_B),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .illegal(illegal)
  );

  function automatic logic [31:0] read_model(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_reg_wr && wb_rd == r) return wb_data;
    return mregs[r];
  endfunction

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // Architectural view: what each instruction class needs, computed from the ISA rules.
  function automatic exp_t model(output bit stall_o);
    exp_t e;
    logic [6:0] op;
    bit u1, u2, stall;
    e = '0;
    op = instr[6:0];
    u1 = 0;
    u2 = 0;
    e.rs1 = (op == 7'b0110111) ? 5'd0 : instr[19:15];
    e.rs2 = instr[24:20];
    e.rd  = instr[11:7];
    e.f7  = instr[31:25];
    e.f3  = instr[14:12];
    case (op)
      7'b0110011: begin e.ctrl = 7'b10_0_0_0_1_0; u1 = 1; u2 = 1; end
      7'b0010011: begin e.ctrl = 7'b11_1_0_0_1_0; u1 = 1;
                        e.imm = 32'(sext(int'(instr[31:20]), 12)); end
      7'b0000011: begin e.ctrl = 7'b00_1_1_0_1_1; u1 = 1;
                        e.imm = 32'(sext(int'(instr[31:20]), 12)); end
      7'b0100011: begin e.ctrl = 7'b00_1_0_1_0_0; u1 = 1; u2 = 1;
                        e.imm = 32'(sext(int'(instr[31:25]) * 32 + int'(instr[11:7]), 12)); end
      7'b0110111: begin e.ctrl = 7'b00_1_0_0_1_0;
                        e.imm = instr & 32'hFFFF_F000; end
      default: ;
    endcase
    stall = ex_mem_rd && ex_rd != 0 &&
            ((u1 && ex_rd == e.rs1) || (u2 && ex_rd == e.rs2));
    if (rst || stall) e.ctrl = '0;
    e.en  = (!rst && stall) ? 2'b00 : 2'b11;
    e.va  = rst ? 32'h0 : read_model(e.rs1);
    e.vb  = rst ? 32'h0 : read_model(e.rs2);
    e.ill = rst ? 1'b0 : mill;
    stall_o = stall;
    return e;
  endfunction

  task automatic step(input logic [31:0] i, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic exm, input logic [4:0] exr,
                      input logic r);
    exp_t e;
    bit st;
    bit legal;
    instr = i; wb_reg_wr = we; wb_rd = wr; wb_data = wd;
    ex_mem_rd = exm; ex_rd = exr; rst = r;
    if (r) begin
      foreach (mregs[k]) mregs[k] = 32'h0;
      mill = 1'b0;
    end
    e = model(st);
    sb_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      if (we && wr != 0) mregs[wr] = wd;
      legal = (i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111});
      if (i != 0 && !legal && !st) mill = 1'b1;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h (instr %h)", name, $time, act, exp, instr);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ctrl",   32'({ula, mux_ula, mem_rd, mem_wr, reg_wr, mux_reg_wr}), 32'(e.ctrl));
      chk("imm",    imm, e.imm);
      chk("fields", 32'({rs1, rs2, rd, funct7, funct3}), 32'({e.rs1, e.rs2, e.rd, e.f7, e.f3}));
      chk("val_A",  val_A, e.va);
      chk("val_B",  val_B, e.vb);
      chk("enable", 32'({pc_enable, if_id_enable}), 32'(e.en));
      chk("illegal", 32'(illegal), 32'(e.ill));
      $display("txn instr=%h rst=%0d ctrl=%b imm=%h A=%h B=%h en=%b ill=%0d",
               instr, rst, {ula, mux_ula, mem_rd, mem_wr, reg_wr, mux_reg_wr},
               imm, val_A, val_B, {pc_enable, if_id_enable}, illegal);
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] ri;
    logic [6:0]  op;
    logic [4:0]  er;
    logic [4:0]  wr;
    foreach (mregs[k]) mregs[k] = 32'h0;
    mill = 1'b0;
    @(posedge clk); #1;
    step(32'h0, 0, 0, 0, 0, 0, 1);                       // reset state
    step(32'h0, 1, 5'd1, 32'd10, 0, 0, 0);
    step(32'h0, 1, 5'd2, 32'h55, 0, 0, 0);
    step(32'h0, 1, 5'd5, 32'h1234, 0, 0, 0);
    step(32'hFFC08193, 0, 0, 0, 0, 0, 0);                // addi x3,x1,-4
    step(32'h0020A423, 0, 0, 0, 0, 0, 0);                // sw x2,8(x1)
    step(32'hABCDE237, 0, 0, 0, 0, 0, 0);                // lui x4,0xABCDE
    step(32'h00738433, 1, 5'd7, 32'hDEAD, 0, 0, 0);      // add x8,x7,x7 bypass
    step(32'h0, 1, 5'd0, 32'd5, 0, 0, 0);                // write x0
    step(32'h00000433, 1, 5'd0, 32'd5, 0, 0, 0);         // add x8,x0,x0
    step(32'h001304B3, 0, 0, 0, 1, 5'd6, 0);             // load-use stall
    step(32'h00608493, 0, 0, 0, 1, 5'd6, 0);             // I-ALU rs2 field 6: no stall
    step(32'h001004B3, 0, 0, 0, 1, 5'd0, 0);             // ex_rd=0: no stall
    step(32'h0000006F, 0, 0, 0, 0, 0, 0);                // JAL -> illegal
    step(32'h0, 0, 0, 0, 0, 0, 0);
    step(32'h00028093, 0, 0, 0, 0, 0, 0);                // reads x5
    step(32'h00028093, 0, 0, 0, 0, 0, 1);                // mid-run reset
    step(32'h00028093, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      case ($urandom_range(0, 7))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b0110111;
        5: op = 7'b1101111;
        6: op = 7'b0000000;
        default: op = r[6:0];
      endcase
      ri = {r[31:7], op};
      if ($urandom_range(0, 7) == 0) ri = 32'h0;
      case ($urandom_range(0, 3))
        0, 1: er = ri[19:15];
        2: er = ri[24:20];
        default: er = 5'($urandom_range(0, 31));
      endcase
      wr = ($urandom_range(0, 1) == 1) ? ri[19:15] : 5'($urandom_range(0, 31));
      step(ri, 1'($urandom_range(0, 1)), wr, $urandom(),
           1'($urandom_range(0, 2) == 0), er, ($urandom_range(0, 49) == 0));
    end
    driver_done = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
